// File: rtl/bn_affine_2d.sv
// bn_affine_2d: per-channel folded batch-norm (x*scale >>> FRAC_BITS + shift), saturate, optional ReLU.
// Latency: N = C*H*W clocks from RUN entry to done; one element written per clock, no stalls.
// Backpressure: none; start is a level request and done holds until start drops.
package backbone_pkg;
  typedef logic signed [15:0] data_t;
endpackage

module bn_affine_2d
  import backbone_pkg::*;
#(
  parameter int C         = 64,
  parameter int H         = 56,
  parameter int W         = 56,
  parameter bit USE_RELU  = 1'b1,
  parameter int FRAC_BITS = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  output logic  done,
  input  data_t fmap_in  [C*H*W],
  input  data_t scale    [C],
  input  data_t shift    [C],
  output data_t fmap_out [C*H*W]
);
  localparam int N     = C * H * W;
  localparam int HW    = H * W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PIX_W = (HW > 1) ? $clog2(HW) : 1;
  localparam int CH_W  = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  data_t            fmap_out_q [N];
  data_t            fmap_out_d [N];
  data_t            result;

  // Channel comes from a pixel-within-channel counter, so no divider is needed.
  always_comb begin
    logic signed [31:0] x_ext;
    logic signed [31:0] sc_ext;
    logic signed [31:0] prod;
    logic signed [31:0] quot;
    logic signed [32:0] sum;
    x_ext  = 32'(fmap_in[idx_q]);
    sc_ext = 32'(scale[ch_q]);
    prod   = x_ext * sc_ext;
    quot   = prod >>> FRAC_BITS;
    sum    = 33'(quot) + 33'(shift[ch_q]);
    if (!sum[32] && (sum[31:15] != '0)) begin
      result = 16'sh7FFF;
    end else if (sum[32] && (sum[31:15] != '1)) begin
      result = 16'sh8000;
    end else begin
      result = sum[15:0];
    end
    if (USE_RELU && result[15]) begin
      result = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    idx_d      = idx_q;
    pix_d      = pix_q;
    ch_d       = ch_q;
    fmap_out_d = fmap_out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          pix_d   = '0;
          ch_d    = '0;
        end
      end
      RUN: begin
        fmap_out_d[idx_q] = result;
        if (idx_q == IDX_W'(N - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          idx_d   = '0;
          pix_d   = '0;
          ch_d    = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (pix_q == PIX_W'(HW - 1)) begin
            pix_d = '0;
            ch_d  = ch_q + CH_W'(1);
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      DONE: begin
        // Only a low start releases DONE, so a held start never re-runs.
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      idx_q   <= '0;
      pix_q   <= '0;
      ch_q    <= '0;
      for (int i = 0; i < N; i++) begin
        fmap_out_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      pix_q      <= pix_d;
      ch_q       <= ch_d;
      fmap_out_q <= fmap_out_d;
    end
  end

  assign done     = done_q;
  assign fmap_out = fmap_out_q;

endmodule

// File: tb/tb_bn_affine_2d.sv
// Directed bench for bn_affine_2d at C=H=W=2, with a ReLU and a pass-through instance side by side.
module tb_bn_affine_2d;
  import backbone_pkg::*;

  localparam int C = 2;
  localparam int H = 2;
  localparam int W = 2;
  localparam int N = C * H * W;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  start = 1'b0;
  logic  done_r, done_l;
  data_t fin   [N];
  data_t sc    [C];
  data_t sh    [C];
  data_t out_r [N];
  data_t out_l [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bn_affine_2d #(.C(C), .H(H), .W(W), .USE_RELU(1'b1), .FRAC_BITS(8)) u_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done_r),
    .fmap_in(fin), .scale(sc), .shift(sh), .fmap_out(out_r)
  );

  bn_affine_2d #(.C(C), .H(H), .W(W), .USE_RELU(1'b0), .FRAC_BITS(8)) u_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done_l),
    .fmap_in(fin), .scale(sc), .shift(sh), .fmap_out(out_l)
  );

  // Raises start and counts edges until both instances report done; start is left high.
  task automatic do_run(output int cyc);
    start = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!(done_r && done_l) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    fin = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h0001};
    sc = '{16'h0100, 16'h0100};
    sh = '{16'h0000, 16'h0000};
    rst_n = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done_r !== 1'b0 || done_l !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b/%b exp=0/0", done_r, done_l);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_r[i] !== 16'h0000 || out_l[i] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_out[%0d] got=%h/%h exp=0000", i, out_r[i], out_l[i]);
      end
    end
    repeat (N + 2) @(negedge clk);
    checks++;
    if (done_r !== 1'b0 || done_l !== 1'b0 || out_r[0] !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold got done=%b/%b out0=%h exp=0/0/0000", done_r, done_l, out_r[0]);
    end
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity;
    logic [15:0] ex_r [N];
    logic [15:0] ex_l [N];
    int cyc;
    fin = '{16'h1234, 16'h1234, 16'hFF00, 16'h1234, 16'hFF00, 16'h0001, 16'h1234, 16'hFF00};
    sc = '{16'h0100, 16'h0100};
    sh = '{16'h0000, 16'h0000};
    ex_r = '{16'h1234, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h0001, 16'h1234, 16'h0000};
    ex_l = '{16'h1234, 16'h1234, 16'hFF00, 16'h1234, 16'hFF00, 16'h0001, 16'h1234, 16'hFF00};
    do_run(cyc);
    checks++;
    if (cyc !== N) begin
      failures++;
      $display("FAIL identity_latency got=%0d exp=%0d", cyc, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_r[i] !== ex_r[i] || out_l[i] !== ex_l[i]) begin
        failures++;
        $display("FAIL identity[%0d] got=%h/%h exp=%h/%h", i, out_r[i], out_l[i], ex_r[i], ex_l[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_per_channel;
    int cyc;
    logic [15:0] ex;
    fin = '{16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040};
    sc = '{16'h0200, 16'h0080};
    sh = '{16'h0010, 16'hFFF0};
    do_run(cyc);
    checks++;
    if (cyc !== N) begin
      failures++;
      $display("FAIL per_channel_latency got=%0d exp=%0d", cyc, N);
    end
    for (int i = 0; i < N; i++) begin
      ex = (i < H * W) ? 16'h0090 : 16'h0010;
      checks++;
      if (out_r[i] !== ex || out_l[i] !== ex) begin
        failures++;
        $display("FAIL per_channel[%0d] got=%h/%h exp=%h", i, out_r[i], out_l[i], ex);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    logic [15:0] ex_r [N];
    logic [15:0] ex_l [N];
    int cyc;
    fin = '{16'h7000, 16'h9000, 16'h0000, 16'h0100, 16'hFFFF, 16'h0100, 16'hFFFE, 16'h0003};
    sc = '{16'h0400, 16'h0080};
    sh = '{16'h0000, 16'h0000};
    ex_l = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0400, 16'hFFFF, 16'h0080, 16'hFFFF, 16'h0001};
    ex_r = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0080, 16'h0000, 16'h0001};
    do_run(cyc);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_r[i] !== ex_r[i] || out_l[i] !== ex_l[i]) begin
        failures++;
        $display("FAIL saturation[%0d] got=%h/%h exp=%h/%h", i, out_r[i], out_l[i], ex_r[i], ex_l[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_handshake;
    int cyc;
    fin = '{16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC};
    sc = '{16'h0100, 16'h0100};
    sh = '{16'h0000, 16'h0000};
    do_run(cyc);
    checks++;
    if (cyc !== N) begin
      failures++;
      $display("FAIL handshake_latency got=%0d exp=%0d", cyc, N);
    end
    fin = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200};
    repeat (N + 3) @(negedge clk);
    checks++;
    if (done_r !== 1'b1 || done_l !== 1'b1) begin
      failures++;
      $display("FAIL handshake_hold_done got=%b/%b exp=1/1", done_r, done_l);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_r[i] !== 16'h0ABC) begin
        failures++;
        $display("FAIL handshake_no_rerun[%0d] got=%h exp=0abc", i, out_r[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done_r !== 1'b0 || done_l !== 1'b0) begin
      failures++;
      $display("FAIL handshake_release got=%b/%b exp=0/0", done_r, done_l);
    end
    do_run(cyc);
    checks++;
    if (cyc !== N) begin
      failures++;
      $display("FAIL handshake_rerun_latency got=%0d exp=%0d", cyc, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_r[i] !== 16'h0200 || out_l[i] !== 16'h0200) begin
        failures++;
        $display("FAIL handshake_rerun[%0d] got=%h/%h exp=0200", i, out_r[i], out_l[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc;
    fin = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    start = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (out_r[2] !== 16'h0100 || out_r[3] !== 16'h0200) begin
      failures++;
      $display("FAIL mid_partial got=%h/%h exp=0100/0200", out_r[2], out_r[3]);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done_r !== 1'b0 || done_l !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_done got=%b/%b exp=0/0", done_r, done_l);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_r[i] !== 16'h0000 || out_l[i] !== 16'h0000) begin
        failures++;
        $display("FAIL mid_reset_out[%0d] got=%h/%h exp=0000", i, out_r[i], out_l[i]);
      end
    end
    rst_n = 1'b0;
    repeat (N + 2) @(negedge clk);
    checks++;
    if (done_r !== 1'b0 || out_r[0] !== 16'h0000) begin
      failures++;
      $display("FAIL mid_idle got done=%b out0=%h exp=0/0000", done_r, out_r[0]);
    end
    do_run(cyc);
    checks++;
    if (cyc !== N) begin
      failures++;
      $display("FAIL mid_rerun_latency got=%0d exp=%0d", cyc, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_r[i] !== 16'h0100 || out_l[i] !== 16'h0100) begin
        failures++;
        $display("FAIL mid_rerun[%0d] got=%h/%h exp=0100", i, out_r[i], out_l[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_per_channel();
    test_saturation();
    test_handshake();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=expired exp=finish");
    $fatal(1, "timeout");
  end

endmodule
